// File: rtl/shift_sequencer.sv
// Sequences load/shift strobes for an 8-bit right-shift datapath and keeps a local copy of it.
// Accepts an operation on start and applies min(amount, WIDTH) shifts, stalling while hold is high.
module shift_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic [CW-1:0]    amount,
  input  logic             asr,
  input  logic             hold,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             load_n,
  output logic             shift_en,
  output logic             asr_sel
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  localparam logic [CW-1:0] MaxCount = CW'(WIDTH);
  localparam logic [CW-1:0] OneCount = CW'(1);

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_result_next;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_next;
  logic             r_asr_sel;
  logic             w_asr_sel_next;
  logic [CW-1:0]    w_amount_clamped;
  logic             w_fill;

  // Amounts beyond the register width saturate: the result is then pure fill.
  assign w_amount_clamped = (amount > MaxCount) ? MaxCount : amount;
  assign w_fill           = r_asr_sel & r_result[WIDTH-1];

  always_comb begin
    w_state_next   = r_state;
    w_result_next  = r_result;
    w_count_next   = r_count;
    w_asr_sel_next = r_asr_sel;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_result_next  = load_val;
          w_asr_sel_next = asr;
          w_count_next   = w_amount_clamped;
          w_state_next   = (w_amount_clamped != '0) ? StShift : StDone;
        end
      end
      StShift: begin
        if (!hold) begin
          w_result_next = {w_fill, r_result[WIDTH-1:1]};
          w_count_next  = r_count - OneCount;
          if (r_count == OneCount) begin
            w_state_next = StDone;
          end
        end
      end
      StDone: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= StIdle;
      r_result  <= '0;
      r_count   <= '0;
      r_asr_sel <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_result  <= w_result_next;
      r_count   <= w_count_next;
      r_asr_sel <= w_asr_sel_next;
    end
  end

  assign busy     = (r_state != StIdle);
  assign done     = (r_state == StDone);
  assign load_n   = ~((r_state == StIdle) & start);
  assign shift_en = (r_state == StShift) & ~hold;
  assign asr_sel  = r_asr_sel;
  assign result   = r_result;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed scenarios plus randomized operations
// compared against a shift-count model of the register contents.
module tb_shift_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       asr = 1'b0;
  logic       hold = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [3:0] amount = 4'h0;
  logic       busy, done, load_n, shift_en, asr_sel;
  logic [7:0] result;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  shift_sequencer #(.WIDTH(8), .CW(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .load_val (load_val),
    .amount   (amount),
    .asr      (asr),
    .hold     (hold),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .load_n   (load_n),
    .shift_en (shift_en),
    .asr_sel  (asr_sel)
  );

  // Value after k right shifts: plain logical or sign-preserving arithmetic division shift.
  function automatic logic [7:0] model_shift(input logic [7:0] v, input int k, input bit a);
    logic signed [7:0] s;
    s = v;
    if (a) return 8'(s >>> k);
    return v >> k;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    hold  = 1'b0;
    repeat (2) @(negedge clock);
    total++; if (result !== 8'h00) begin bad++; $display("FAIL reset_result got=%h exp=00", result); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    reset = 1'b1;
    @(negedge clock);
    #1;
    total++; if (result !== 8'h00) begin bad++; $display("FAIL rel_result got=%h exp=00", result); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rel_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rel_done got=%b exp=0", done); end
    total++; if (load_n !== 1'b1) begin bad++; $display("FAIL rel_load_n got=%b exp=1", load_n); end
    total++; if (shift_en !== 1'b0) begin bad++; $display("FAIL rel_shift_en got=%b exp=0", shift_en); end
    total++; if (asr_sel !== 1'b0) begin bad++; $display("FAIL rel_asr_sel got=%b exp=0", asr_sel); end
  endtask

  // Runs one operation from IDLE; must be entered just after a negedge.
  task automatic run_op(input logic [7:0] lv, input logic [3:0] amt, input bit a,
                        input int hold_at, input int hold_len, input bit poke);
    int n, k, held, cyc;
    bit hnow;
    logic [7:0] exp_v;
    n = (amt > 4'd8) ? 8 : int'(amt);
    k = 0;
    held = 0;
    cyc = 0;
    load_val = lv; amount = amt; asr = a; start = 1'b1; hold = 1'b0;
    #1;
    total++; if (load_n !== 1'b0) begin bad++; $display("FAIL acc_load_n got=%b exp=0", load_n); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL acc_busy got=%b exp=0", busy); end
    @(negedge clock);
    start = 1'b0;
    load_val = 8'($urandom);
    amount = 4'($urandom);
    asr = 1'($urandom);
    while (1) begin
      hnow = (k == hold_at) && (held < hold_len);
      hold = hnow;
      if (poke) start = 1'($urandom_range(0, 1));
      #1;
      exp_v = model_shift(lv, k, a);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL op_busy k=%0d got=%b exp=1", k, busy); end
      total++; if (done !== (k == n)) begin bad++; $display("FAIL op_done k=%0d got=%b exp=%b", k, done, k == n); end
      total++;
      if (shift_en !== (k < n && !hnow)) begin
        bad++; $display("FAIL op_shift_en k=%0d got=%b exp=%b", k, shift_en, k < n && !hnow);
      end
      total++; if (result !== exp_v) begin bad++; $display("FAIL op_result k=%0d got=%h exp=%h", k, result, exp_v); end
      total++; if (asr_sel !== a) begin bad++; $display("FAIL op_asr_sel got=%b exp=%b", asr_sel, a); end
      if (k == n) break;
      if (hnow) held++;
      else k++;
      cyc++;
      if (cyc > 40) begin
        bad++; total++; $display("FAIL op_timeout got=%0d cycles exp<=40", cyc);
        break;
      end
      @(negedge clock);
    end
    @(negedge clock);
    start = 1'b0;
    hold = 1'b0;
    #1;
    exp_v = model_shift(lv, n, a);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL end_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL end_done got=%b exp=0", done); end
    total++; if (result !== exp_v) begin bad++; $display("FAIL end_result got=%h exp=%h", result, exp_v); end
    total++; if (load_n !== 1'b1) begin bad++; $display("FAIL end_load_n got=%b exp=1", load_n); end
    @(negedge clock);
    #1;
    total++; if (result !== exp_v) begin bad++; $display("FAIL idle_hold got=%h exp=%h", result, exp_v); end
    @(negedge clock);
  endtask

  task automatic test_basic();
    run_op(8'hB4, 4'd3, 1'b0, -1, 0, 1'b0);
    run_op(8'hB4, 4'd3, 1'b1, -1, 0, 1'b0);
    run_op(8'hB4, 4'd0, 1'b0, -1, 0, 1'b0);
  endtask

  task automatic test_clamp();
    run_op(8'h81, 4'd12, 1'b0, -1, 0, 1'b0);
    run_op(8'h81, 4'd12, 1'b1, -1, 0, 1'b0);
    run_op(8'h81, 4'd15, 1'b1, -1, 0, 1'b0);
  endtask

  task automatic test_hold();
    run_op(8'hC3, 4'd4, 1'b1, 2, 3, 1'b1);
    run_op(8'h5A, 4'd4, 1'b0, 2, 3, 1'b1);
  endtask

  task automatic test_reset_mid();
    load_val = 8'hA5; amount = 4'd5; asr = 1'b1; start = 1'b1; hold = 1'b0;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    total++;
    if (result !== model_shift(8'hA5, 2, 1'b1)) begin
      bad++; $display("FAIL mid_result got=%h exp=%h", result, model_shift(8'hA5, 2, 1'b1));
    end
    reset = 1'b0;
    @(negedge clock);
    #1;
    total++; if (result !== 8'h00) begin bad++; $display("FAIL rst_mid_result got=%h exp=00", result); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    total++; if (asr_sel !== 1'b0) begin bad++; $display("FAIL rst_mid_asr_sel got=%b exp=0", asr_sel); end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      #1;
      total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_mid_done i=%0d got=%b exp=0", i, done); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_idle i=%0d got=%b exp=0", i, busy); end
    end
    @(negedge clock);
    run_op(8'hA5, 4'd5, 1'b1, -1, 0, 1'b0);
  endtask

  // start held high: ignored in SHIFT/DONE, accepted at the first IDLE edge with the new value.
  task automatic test_back_to_back();
    load_val = 8'h3C; amount = 4'd1; asr = 1'b0; start = 1'b1; hold = 1'b0;
    @(negedge clock);
    load_val = 8'h99; amount = 4'd0;
    #1;
    total++; if (shift_en !== 1'b1) begin bad++; $display("FAIL b2b_shift got=%b exp=1", shift_en); end
    total++; if (result !== 8'h3C) begin bad++; $display("FAIL b2b_load got=%h exp=3c", result); end
    @(negedge clock);
    #1;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done1 got=%b exp=1", done); end
    total++; if (result !== 8'h1E) begin bad++; $display("FAIL b2b_res1 got=%h exp=1e", result); end
    @(negedge clock);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b exp=0", busy); end
    total++; if (load_n !== 1'b0) begin bad++; $display("FAIL b2b_load_n got=%b exp=0", load_n); end
    total++; if (result !== 8'h1E) begin bad++; $display("FAIL b2b_keep got=%h exp=1e", result); end
    @(negedge clock);
    start = 1'b0;
    #1;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done2 got=%b exp=1", done); end
    total++; if (result !== 8'h99) begin bad++; $display("FAIL b2b_res2 got=%h exp=99", result); end
    @(negedge clock);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b exp=0", busy); end
    @(negedge clock);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_op(8'($urandom), 4'($urandom), 1'($urandom),
             ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 8)),
             int'($urandom_range(0, 3)), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Autonomous controller for the 8-bit right-shift register datapath (per-bit load/shift mux + flip-flop chain with logical/arithmetic fill). It accepts a load value, shift amount and fill mode on a start pulse, then sequences load_n/shift/asr over successive cycles until the requested number of shifts is applied, and reports completion. It holds its own copy of the shift register so the result is observable, and exports the control strobes so the same sequence can drive an external shifter instance.

Parameters:
WIDTH, 8, datapath width in bits.
CW, 4, width of the shift-amount input; must satisfy 2^CW > WIDTH.

Ports:
clock  input  1  system clock; all state updates on posedge.
reset  input  1  synchronous, active-low reset.
start  input  1  request; sampled only in IDLE.
load_val  input  WIDTH  value loaded into register on accepted start.
amount  input  CW  number of right shifts requested.
asr  input  1  1 = arithmetic fill (MSB replicated), 0 = logical fill (zero).
hold  input  1  stalls shifting while high; state and count frozen.
busy  output  1  high from accepted start until the DONE cycle ends.
done  output  1  one-cycle completion pulse.
result  output  WIDTH  current register contents.
load_n  output  1  active-low load strobe to external shifter.
shift_en  output  1  shift strobe to external shifter.
asr_sel  output  1  latched fill mode to external shifter.

Behaviour:
- Reset: reset==0 at posedge -> state IDLE, result=0, count=0, asr_sel=0, busy=0, done=0. Reset dominates every other input, including mid-operation; a partially shifted value is discarded.
- States: IDLE, SHIFT, DONE (2-bit encoding).
- IDLE: if start==1 at posedge -> result<=load_val, asr_sel<=asr, count<=min(amount, WIDTH); next state SHIFT if clamped count!=0, else DONE. If start==0 -> stay, result holds.
- SHIFT: on each posedge with hold==0 -> result<={fill, result[WIDTH-1:1]}, fill = asr_sel ? result[WIDTH-1] : 0; count<=count-1; when count==1 before the edge -> next state DONE. hold==1 -> no change.
- DONE: done=1 for exactly one cycle; result stable; next posedge -> IDLE.
- Clamp: amount>WIDTH is treated as WIDTH (logical -> all zeros, arithmetic -> all sign bits); max busy duration WIDTH+1 cycles plus hold stalls.
- Latency: numbering the accepting edge as edge 0, done is high in the cycle after edge N (N = clamped amount), hold cycles excluded.
- Combinational outputs: busy = (state != IDLE); load_n = ~(state==IDLE & start); shift_en = (state==SHIFT & ~hold); done = (state==DONE).
- start while busy (SHIFT or DONE) is ignored, not queued; a start held high through DONE is accepted at the first IDLE edge.
- asr, amount, load_val changes after acceptance have no effect on the running operation.
- result persists after DONE until the next accepted start or reset.

Test Plan:
- Reset low 2 cycles, release -> result=0x00, busy=0, done=0, load_n=1, shift_en=0.
- load_val=0xB4, amount=3, asr=0, start 1 cycle -> busy 4 cycles, shift_en high 3 cycles, done in cycle after edge 3, result=0x16.
- Same with asr=1 -> result=0xF6, asr_sel=1 throughout; amount=0 with load_val=0xB4 -> done the cycle after start, result=0xB4, shift_en never high.
- load_val=0x81, amount=12: asr=0 -> result=0x00 after 8 shifts; asr=1 -> result=0xFF; busy exactly 9 cycles each.
- amount=4, hold high for 3 cycles after the second shift -> result unchanged during hold, done delayed 3 cycles, final result correct; start pulses during SHIFT/DONE ignored.
- Reset low during SHIFT (after 2 of 5 shifts) -> next edge IDLE, result=0x00, no done pulse; a subsequent start operates normally.
